// File: rtl/perf_counter_sequencer.sv
// Avalon-MM master that turns per-section start/stop/clear pulses into counter
// control writes and performs a rollover-safe snapshot read of one section.
module perf_counter_sequencer #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  start_req,
    input  logic [3:0]  stop_req,
    input  logic        clr_req,
    input  logic        snap_req,
    input  logic [1:0]  snap_sel,
    output logic        snap_ready,
    output logic        snap_valid,
    output logic [63:0] snap_time,
    output logic [31:0] snap_events,
    output logic        busy,
    output logic [3:0]  avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    // state  | meaning
    // IDLE   | arbitrate: clear > section writes (round-robin) > snapshot
    // WRITE  | hold write command until accepted
    // RD_HI1 | read time hi (first)
    // RD_LO  | read time lo
    // RD_HI2 | read time hi again, compare with first
    // RD_LO2 | hi moved between reads: re-read time lo
    // RD_EVT | read event counter
    // DONE   | publish snapshot result
    typedef enum logic [2:0] {
        IDLE, WRITE, RD_HI1, RD_LO, RD_HI2, RD_LO2, RD_EVT, DONE
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    state_t      state;
    logic [3:0]  pend_start, pend_stop;
    logic        pend_clr;
    logic [1:0]  rr, g_sec, snap_sec, lat_cnt;
    logic        g_clr, g_stop, rd_wait;
    logic [31:0] hi1, hi2, lo, evt;

    logic        sec_found, accept, nxt_idle, clr_clr_mask;
    logic [1:0]  sec_grant, rr_idx;
    logic [3:0]  clr_start_mask, clr_stop_mask;
    logic [3:0]  pend_start_nxt, pend_stop_nxt;
    logic        pend_clr_nxt;

    always_comb begin
        sec_found = 1'b0;
        sec_grant = rr;
        rr_idx    = rr;
        for (int i = 0; i < 4; i++) begin
            rr_idx = rr + 2'(i);
            if (!sec_found && (pend_start[rr_idx] || pend_stop[rr_idx])) begin
                sec_found = 1'b1;
                sec_grant = rr_idx;
            end
        end
    end

    always_comb begin
        accept         = (state == WRITE) && !avm_waitrequest;
        clr_clr_mask   = 1'b0;
        clr_start_mask = 4'b0;
        clr_stop_mask  = 4'b0;
        if (accept) begin
            if (g_clr)
                clr_clr_mask = 1'b1;
            else if (g_stop)
                clr_stop_mask[g_sec] = 1'b1;
            else
                clr_start_mask[g_sec] = 1'b1;
        end
        // a new pulse on the accept edge survives the clear
        pend_start_nxt = (pend_start & ~clr_start_mask) | start_req;
        pend_stop_nxt  = (pend_stop & ~clr_stop_mask) | stop_req;
        pend_clr_nxt   = (pend_clr & ~clr_clr_mask) | clr_req;
        nxt_idle = (state == IDLE && !(pend_clr || sec_found || snap_req)) ||
                   accept || (state == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pend_start    <= 4'b0;
            pend_stop     <= 4'b0;
            pend_clr      <= 1'b0;
            rr            <= 2'd0;
            g_sec         <= 2'd0;
            g_clr         <= 1'b0;
            g_stop        <= 1'b0;
            snap_sec      <= 2'd0;
            lat_cnt       <= 2'd0;
            rd_wait       <= 1'b0;
            hi1           <= 32'b0;
            hi2           <= 32'b0;
            lo            <= 32'b0;
            evt           <= 32'b0;
            snap_ready    <= 1'b1;
            snap_valid    <= 1'b0;
            snap_time     <= 64'b0;
            snap_events   <= 32'b0;
            busy          <= 1'b0;
            avm_address   <= 4'b0;
            avm_write     <= 1'b0;
            avm_read      <= 1'b0;
            avm_writedata <= 32'b0;
        end else begin
            pend_start <= pend_start_nxt;
            pend_stop  <= pend_stop_nxt;
            pend_clr   <= pend_clr_nxt;
            snap_ready <= nxt_idle;
            busy       <= !nxt_idle || pend_clr_nxt || (|pend_start_nxt) || (|pend_stop_nxt);
            snap_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (pend_clr) begin
                        g_clr         <= 1'b1;
                        avm_address   <= 4'd0;
                        avm_writedata <= 32'd1;
                        avm_write     <= 1'b1;
                        state         <= WRITE;
                    end else if (sec_found) begin
                        g_clr         <= 1'b0;
                        g_sec         <= sec_grant;
                        g_stop        <= pend_stop[sec_grant];
                        avm_address   <= {sec_grant, 1'b0, ~pend_stop[sec_grant]};
                        avm_writedata <= 32'd0;
                        avm_write     <= 1'b1;
                        state         <= WRITE;
                    end else if (snap_req) begin
                        snap_sec    <= snap_sel;
                        avm_address <= {snap_sel, 2'b01};
                        avm_read    <= 1'b1;
                        rd_wait     <= 1'b0;
                        state       <= RD_HI1;
                    end
                end
                WRITE: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        if (!g_clr)
                            rr <= g_sec + 2'd1;
                        state <= IDLE;
                    end
                end
                RD_HI1, RD_LO, RD_HI2, RD_LO2, RD_EVT: begin
                    if (!rd_wait) begin
                        if (!avm_waitrequest) begin
                            avm_read <= 1'b0;
                            rd_wait  <= 1'b1;
                            lat_cnt  <= LAT_INIT;
                        end
                    end else if (lat_cnt != 2'd0) begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end else begin
                        rd_wait <= 1'b0;
                        case (state)
                            RD_HI1: begin
                                hi1         <= avm_readdata;
                                avm_address <= {snap_sec, 2'b00};
                                avm_read    <= 1'b1;
                                state       <= RD_LO;
                            end
                            RD_LO: begin
                                lo          <= avm_readdata;
                                avm_address <= {snap_sec, 2'b01};
                                avm_read    <= 1'b1;
                                state       <= RD_HI2;
                            end
                            RD_HI2: begin
                                hi2      <= avm_readdata;
                                avm_read <= 1'b1;
                                if (avm_readdata == hi1) begin
                                    avm_address <= {snap_sec, 2'b10};
                                    state       <= RD_EVT;
                                end else begin
                                    avm_address <= {snap_sec, 2'b00};
                                    state       <= RD_LO2;
                                end
                            end
                            RD_LO2: begin
                                lo          <= avm_readdata;
                                avm_address <= {snap_sec, 2'b10};
                                avm_read    <= 1'b1;
                                state       <= RD_EVT;
                            end
                            default: begin
                                evt   <= avm_readdata;
                                state <= DONE;
                            end
                        endcase
                    end
                end
                DONE: begin
                    snap_time   <= {hi2, lo};
                    snap_events <= evt;
                    snap_valid  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/perf_counter_sequencer.md
# perf_counter_sequencer

Avalon-MM master that drives the four-section performance-counter control slave on behalf of hardware requesters. It converts per-section start/stop pulses and a global-clear pulse into the counter's go/stop register writes, arbitrating fairly between sections. It also performs a rollover-safe snapshot read (64-bit time, 32-bit events) of one section. It sits between the accelerator/event logic and the counter slave in the processor system.

## Interface
- READ_LATENCY, 1, fixed slave read latency in cycles from accepted read to valid `avm_readdata` (legal 1..3)
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- start_req  in  4  one-cycle pulse per section: request go-strobe write
- stop_req  in  4  one-cycle pulse per section: request stop-strobe write
- clr_req  in  1  one-cycle pulse: request global reset (write 1 to address 0)
- snap_req  in  1  snapshot request, accepted when `snap_ready`=1
- snap_sel  in  2  section to snapshot, sampled with `snap_req`
- snap_ready  out  1  high in IDLE with no snapshot in progress
- snap_valid  out  1  one-cycle pulse: snapshot result valid
- snap_time  out  64  section time counter {hi,lo}, held until next snapshot
- snap_events  out  32  section event counter, held until next snapshot
- busy  out  1  high when FSM not IDLE or any request pending
- avm_address  out  4  word address to counter slave
- avm_write  out  1  write command
- avm_read  out  1  read command
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall

## Operation
- Pending bits: pend_start[s], pend_stop[s], pend_clr set by the respective pulse; cleared at the edge their write is accepted (`avm_write & !avm_waitrequest`). A pulse in the same cycle as the clear re-sets the bit (set wins). Repeated pulses while pending merge into one write.
- Address map: stop s -> 4s, go s -> 4s+1; reads: time lo 4s, time hi 4s+1, events 4s+2. Stop/go writedata = 0; clear = address 0, writedata = 1.
- Arbitration in IDLE, one command chosen per visit, priority: clr > section writes (round-robin) > accepted snapshot.
- Round-robin: pointer rr (2 bits, reset 0); search sections rr, rr+1, ... mod 4 for any pending bit; in the granted section stop is issued before start. rr <- granted+1 after the accepted write.
- Clear does not alter pend_start/pend_stop; they are issued afterwards.
- FSM states: IDLE, WRITE, RD_HI1, RD_LO, RD_HI2, RD_LO2, RD_EVT, DONE. Each RD_* state asserts `avm_read` until accepted, then waits READ_LATENCY cycles, captures `avm_readdata`, and advances.
- Snapshot sequence: RD_HI1 -> RD_LO -> RD_HI2; if hi2 == hi1 -> RD_EVT, else RD_LO2 (re-read lo) -> RD_EVT. Result time = {hi2, lo or lo2}. RD_EVT -> DONE (snap_valid=1, outputs updated) -> IDLE.
- snap_req is accepted in IDLE only when no clr or section request is pending; it is latched (with snap_sel) and snap_ready drops until DONE. Writes arriving mid-snapshot stay pending until IDLE.

## Timing
- All outputs registered. Reset values: avm_write=0, avm_read=0, avm_address=0, avm_writedata=0, snap_valid=0, snap_time=0, snap_events=0, snap_ready=1, busy=0, rr=0, all pending bits 0.
- Pulse at cycle t -> pending at t+1 -> avm_write asserted from t+2 (IDLE decides at t+1).
- Command held stable while avm_waitrequest=1. Back-to-back writes: minimum 2 cycles each (WRITE then IDLE).
- Snapshot, no stall, READ_LATENCY=1, no hi change: 4 reads x 2 cycles + DONE; snap_valid 10 cycles after snap_req acceptance.
- Reset asserted mid-transaction: avm_write/avm_read drop asynchronously; all pending requests lost.

## Test plan
- start_req[2] pulse, no stall -> one write addr 9 data 0, two cycles later; pend cleared; busy falls.
- start_req[0..3] same cycle, rr=0 -> writes to 1, 5, 9, 13 in order; then start_req[0]+start_req[3] -> 13 only if rr=0... rr=0 after 13 granted, so order 1, 13.
- stop_req[1] and start_req[1] same cycle plus clr_req -> writes (0,1), (4,0), (5,0) in that order.
- avm_waitrequest held 5 cycles on write -> address/data stable, single accepted write; duplicate start_req[1] pulse during stall -> merged (set wins, one extra write only if pulse on accept cycle).
- Snapshot sel=3, slave returns hi1=0x5, lo=0xFFFFFFFF, hi2=0x6, lo2=0x2, events=0x10 -> reads 13,12,13,12,14; snap_time=0x0000000600000002, snap_events=0x10.
- reset_n low during RD_LO -> avm_read=0 immediately; after release snap_ready=1, no snap_valid.
